// File: rtl/alien_rom_arbiter.sv
// Round-robin arbiter sharing the single-port Alien sprite ROM among NREQ
// sprite requesters. Grants are issued combinationally. Each pixel comes back
// to its owner two cycles later with a one-hot valid tag. Out-of-range
// addresses read ROM entry 0 and return OOR_PIXEL instead of ROM data.
module alien_rom_arbiter #(
  parameter int            NREQ      = 4,
  parameter int            AW        = 10,
  parameter int            DW        = 8,
  parameter int            DEPTH     = 806,
  parameter logic [DW-1:0] OOR_PIXEL = {DW{1'b0}}
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_dout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_oor
);

  localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  // Returned pixel: transparent substitute for out-of-range reads.
  function automatic logic [DW-1:0] pick_pixel(input logic oor,
                                               input logic [DW-1:0] dout);
    return oor ? OOR_PIXEL : dout;
  endfunction

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] gnt_p0;
  logic [PW-1:0]   win_p0;
  logic [PW-1:0]   cand;
  logic            hit_p0;
  logic [AW-1:0]   sel_p0;
  logic            in_rng_p0;
  logic            oor_p0;
  logic [NREQ-1:0] own_p1;
  logic            oor_p1;

  // ---- stage p0: grant cycle (combinational arbitration and ROM address) ----
  // Reset and the active-video strobe both suppress grants.
  assign masked = req & {NREQ{en & rst_n}};

  // Round-robin search starting just after the last winner.
  always_comb begin
    gnt_p0 = '0;
    win_p0 = ptr;
    hit_p0 = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!hit_p0 && masked[cand]) begin
        hit_p0         = 1'b1;
        win_p0         = cand;
        gnt_p0[cand]   = 1'b1;
      end
    end
  end

  // Route the winner's address to the ROM, forcing 0 when idle or out of range.
  always_comb begin
    sel_p0    = addr[win_p0*AW +: AW];
    in_rng_p0 = ({1'b0, sel_p0} < DEPTH_X);
    oor_p0    = hit_p0 && !in_rng_p0;
    rom_addr  = (hit_p0 && in_rng_p0) ? sel_p0 : '0;
  end

  assign gnt = gnt_p0;

  // Pointer remembers the last winner; requester 0 leads after reset.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      ptr <= PW'(NREQ - 1);
    end else if (hit_p0) begin
      ptr <= win_p0;
    end
  end

  // ---- stage p1: tag travels alongside the ROM's registered read ----
  // Capture owner and out-of-range flag of this cycle's grant.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      own_p1 <= '0;
      oor_p1 <= 1'b0;
    end else begin
      own_p1 <= gnt_p0;
      oor_p1 <= oor_p0;
    end
  end

  // ---- stage p2: response register ----
  // Deliver pixel to its owner; data holds when no response is due.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_oor   <= 1'b0;
    end else begin
      rsp_valid <= own_p1;
      rsp_oor   <= oor_p1;
      if (|own_p1) begin
        rsp_data <= pick_pixel(oor_p1, rom_dout);
      end
    end
  end

endmodule

// File: doc/alien_rom_arbiter.md
# alien_rom_arbiter

Round-robin arbiter that shares one single-port sprite ROM among several sprite requesters in the Bee Invaders pixel pipeline. The ROM has 806 entries (31 x 26 pixels), 8-bit pixels and one cycle of registered read latency. This block grants at most one requester per clk_pix cycle and drives the shared ROM address. It returns each pixel to its owner with a one-hot valid tag, and it substitutes a transparent pixel for out-of-range addresses. It sits between the per-alien sprite position/address generators and the Alien ROM instance, in the 25.2 MHz pixel clock domain.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8)
- AW, 10: ROM address width
- DW, 8: pixel width
- DEPTH, 806: valid ROM entries; addresses >= DEPTH are out of range
- OOR_PIXEL, 8'h00: pixel returned for out-of-range addresses

Ports:
- clk_pix  input  1  pixel clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  1  grant enable (active-video strobe); 0 blocks new grants
- req  input  NREQ  per-requester read request, level-held until granted
- addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- gnt  output  NREQ  one-hot grant, combinational, same cycle as acceptance
- rom_addr  output  AW  address to ROM, combinational from the granted requester
- rom_dout  input  DW  ROM registered output, valid one cycle after rom_addr
- rsp_valid  output  NREQ  one-hot response strobe, registered
- rsp_data  output  DW  response pixel, registered
- rsp_oor  output  1  response came from an out-of-range address

## Operation
- Arbitration: round-robin over req & {NREQ{en}}.
  - Search starts at index ptr+1 and wraps modulo NREQ.
  - The first asserted index wins.
  - gnt is one-hot or all-zero. It is never asserted when en=0 or rst_n=0.
- Pointer: ptr <= winner index on every grant; unchanged otherwise.
  - Reset value ptr = NREQ-1, so requester 0 has top priority after reset.
- ROM address:
  - With a grant and addr_i < DEPTH: rom_addr = addr_i.
  - With a grant and addr_i >= DEPTH: rom_addr = 0.
  - With no grant: rom_addr = 0.
- Pipeline: two tag stages carry {one-hot owner, oor bit}.
  - Stage 1 (s1) registers the grant cycle.
  - Stage 2 is the output register. It loads rsp_valid <= s1 owner, rsp_data <= (s1 oor ? OOR_PIXEL : rom_dout), and rsp_oor <= s1 oor.
  - When s1 holds no grant: rsp_valid=0, rsp_oor=0, and rsp_data holds its previous value.
- Throughput: one grant per cycle, sustained; no back-pressure on responses. A requester must consume a response in the cycle rsp_valid is high.
- A requester may keep req high across consecutive cycles. Each cycle in which it is granted is a separate read. It may change addr between grants.
- en=0: no new grants; ptr holds; requests already in flight complete normally.

## Timing
- Cycle t: req_i high, en=1, i wins. gnt[i]=1 and rom_addr are valid in cycle t. The ROM samples at the end of t.
- Cycle t+1: rom_dout is valid; s1 holds the tag.
- Cycle t+2: rsp_valid[i]=1 and rsp_data = pixel. Latency is fixed at 2 cycles from grant.
- All NREQ requesters asserting continuously: grant order is 0,1,...,NREQ-1,0,... Each requester gets exactly 1 of every NREQ cycles.
- Single requester asserting continuously: granted every cycle.
- Reset (rst_n=0 sampled at an edge) has these values after that edge:
  - rsp_valid=0, rsp_data=0, rsp_oor=0
  - s1 tag cleared
  - ptr=NREQ-1
  - gnt=0 and rom_addr=0 for the whole time rst_n is low
- Reset mid-operation: in-flight responses are discarded, with no rsp_valid for grants made before reset. The first grant after rst_n rises responds 2 cycles later.
- Boundary addresses:
  - addr = DEPTH-1 (805): in range, normal ROM read.
  - addr = DEPTH (806) up to 1023: out of range.
- Simultaneous grant and en falling: en is sampled combinationally, so en=0 in cycle t means no grant in t.

## Test plan
- Reset then single read:
  - Stimulus: rst_n low 3 cycles, release. req=4'b0001, addr0=10'd5 for one cycle. ROM model returns 8'hA5 for address 5.
  - Response: gnt=0001 in t. rsp_valid=0001 and rsp_data=A5 in t+2. rsp_valid=0 in all other cycles.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held 12 cycles.
  - Response: gnt sequence 0001,0010,0100,1000 repeating, 3 grants each. Responses follow the same order 2 cycles later.
- Fairness after partial activity:
  - Stimulus: req=4'b0101 held 4 cycles after reset.
  - Response: gnt 0001,0100,0001,0100.
- Out-of-range:
  - Stimulus: addr1=805, then addr1=806, then addr1=1023.
  - Response: first rsp_data = ROM[805] with rsp_oor=0. Next two: rom_addr=0, rsp_data=00, rsp_oor=1.
- en gating and drain:
  - Stimulus: req=4'b0011; en drops in cycle 3.
  - Response: grants in cycles 0..2 only. Responses still arrive in cycles 2..4. ptr is frozen, and after en rises the next grant goes to the requester after the last winner.
- Reset mid-flight:
  - Stimulus: grant in cycle t, rst_n=0 at edge t+1.
  - Response: no rsp_valid at t+2. Outputs hold reset values while reset is held. First grant after release goes to requester 0.
